// File: rtl/sdma_sap_scan_ctrl_pkg.sv
// Purpose : shared types and default widths for the SAP scan controller.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding (IDLE/CHECK/SCAN/DONE) and default counter/padding widths.
package sdma_sap_scan_ctrl_pkg;

  localparam int SC_CW = 16;  // channel counter/extent width
  localparam int SC_XW = 16;  // x counter/extent width
  localparam int SC_YW = 16;  // y counter/extent width
  localparam int SC_PW = 8;   // padding field width

  typedef enum logic [1:0] {
    SC_IDLE  = 2'd0,
    SC_CHECK = 2'd1,
    SC_SCAN  = 2'd2,
    SC_DONE  = 2'd3
  } sc_state_e;

endpackage

// File: rtl/sdma_sap_scan_ctrl_if.sv
// Purpose : coordinate + element-beat bundle between the scan controller and the padding indicator / datapath.
// Latency : n/a (wires only).
// Backpressure: elem_valid/elem_ready; master holds coordinates, pad and last while !elem_ready.
// Ports   : master drives sfms{c,x,y}cnt, elem_valid/pad/last; slave drives elem_ready and padding_flag.
interface sdma_sap_scan_ctrl_if
  import sdma_sap_scan_ctrl_pkg::*;
#(
  parameter int CW = SC_CW,
  parameter int XW = SC_XW,
  parameter int YW = SC_YW
);

  logic [CW-1:0] sfmsccnt;
  logic [XW-1:0] sfmsxcnt;
  logic [YW-1:0] sfmsycnt;
  logic          padding_flag;  // combinational from the indicator, looks at the counters
  logic          elem_valid;
  logic          elem_ready;
  logic          elem_pad;
  logic          elem_last;

  modport master (
    output sfmsccnt, sfmsxcnt, sfmsycnt, elem_valid, elem_pad, elem_last,
    input  elem_ready, padding_flag
  );

  modport slave (
    input  sfmsccnt, sfmsxcnt, sfmsycnt, elem_valid, elem_pad, elem_last,
    output elem_ready, padding_flag
  );

endinterface

// File: rtl/sdma_sap_scan_ctrl_axis_cnt.sv
// Purpose : one-axis wrap counter; counts 0..ext-1 and wraps, wrap feeds the next axis.
// Latency : count updates one cycle after inc_i; at_end_o/wrap_o are combinational.
// Backpressure: none; the caller gates inc_i with its handshake.
// Ports   : i_clk/i_rst, clr_i (sync clear, wins), inc_i, ext_i -> cnt_o, at_end_o, wrap_o.
module sdma_sap_scan_ctrl_axis_cnt #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] ext_i,
  output logic [W-1:0] cnt_o,
  output logic         at_end_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign at_end_o = (cnt_q == ext_i - W'(1));
  assign wrap_o   = inc_i & at_end_o;
  assign cnt_o    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = at_end_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sdma_sap_scan_ctrl.sv
// Purpose : walks every destination-fms coordinate (c, then x, then y, padded border included) and issues one beat each.
// Latency : start at t, extent check at t+1, first beat valid at t+2; done pulses the cycle after the last handshake.
// Backpressure: valid/ready; valid, counters and last hold while !ready, counters advance only on a handshake.
// Ports   : i_clk/i_rst (async, active-high); start/abort/config inputs; sc_if (coordinates + beat port);
//           o_sap_sc_busy/done/cfg_err. Optional SDMA_SAP_SCAN_PERF_EN adds o_sap_sc_pad_beats/o_sap_sc_data_beats.
module sdma_sap_scan_ctrl
  import sdma_sap_scan_ctrl_pkg::*;
#(
  parameter int CW = SC_CW,
  parameter int XW = SC_XW,
  parameter int YW = SC_YW,
  parameter int PW = SC_PW
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sap_sc_start,
  input  logic                 i_sap_sc_abort,
  input  logic                 i_sap_sc_paddingen,
  input  logic [CW-1:0]        i_sap_sc_srcfmsc,
  input  logic [XW-1:0]        i_sap_sc_srcfmsx,
  input  logic [YW-1:0]        i_sap_sc_srcfmsy,
  input  logic [PW-1:0]        i_sap_sc_padl_x,
  input  logic [PW-1:0]        i_sap_sc_padr_x,
  input  logic [PW-1:0]        i_sap_sc_padl_y,
  input  logic [PW-1:0]        i_sap_sc_padr_y,
  sdma_sap_scan_ctrl_if.master sc_if,
  output logic                 o_sap_sc_busy,
  output logic                 o_sap_sc_done,
  output logic                 o_sap_sc_cfg_err
`ifdef SDMA_SAP_SCAN_PERF_EN
  ,
  output logic [31:0]          o_sap_sc_pad_beats,
  output logic [31:0]          o_sap_sc_data_beats
`endif
);

  sc_state_e state_q, state_d;

  // Extents carry one spare bit so an overflowing padded sum is visible in CHECK.
  logic [CW-1:0] ext_c_q;
  logic [XW:0]   ext_x_q, ext_x_d;
  logic [YW:0]   ext_y_q, ext_y_d;
  logic          cfg_err_q;

  logic          start_acc;
  logic          ext_ovf;
  logic          ext_zero;
  logic          elem_vld;
  logic          elem_hs;
  logic          cnt_clr;

  logic [CW-1:0] cnt_c;
  logic [XW-1:0] cnt_x;
  logic [YW-1:0] cnt_y;
  logic          at_end_c, at_end_x, at_end_y;
  logic          wrap_c, wrap_x, wrap_y;

  // Abort wins over a simultaneous start in IDLE.
  assign start_acc = (state_q == SC_IDLE) && i_sap_sc_start && !i_sap_sc_abort;

  always_comb begin
    ext_x_d = {1'b0, i_sap_sc_srcfmsx};
    ext_y_d = {1'b0, i_sap_sc_srcfmsy};
    if (i_sap_sc_paddingen) begin
      ext_x_d = {1'b0, i_sap_sc_srcfmsx} + (XW+1)'(i_sap_sc_padl_x) + (XW+1)'(i_sap_sc_padr_x);
      ext_y_d = {1'b0, i_sap_sc_srcfmsy} + (YW+1)'(i_sap_sc_padl_y) + (YW+1)'(i_sap_sc_padr_y);
    end
  end

  // Configuration is captured only on an accepted start; later input changes are ignored.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ext_c_q <= '0;
      ext_x_q <= '0;
      ext_y_q <= '0;
    end else if (start_acc) begin
      ext_c_q <= i_sap_sc_srcfmsc;
      ext_x_q <= ext_x_d;
      ext_y_q <= ext_y_d;
    end
  end

  assign ext_ovf  = ext_x_q[XW] | ext_y_q[YW];
  // Only meaningful when ext_ovf is clear, so the spare bits are zero.
  assign ext_zero = (ext_c_q == '0) || (ext_x_q[XW-1:0] == '0) || (ext_y_q[YW-1:0] == '0);

  assign elem_vld = (state_q == SC_SCAN);
  assign elem_hs  = elem_vld && sc_if.elem_ready && !i_sap_sc_abort;
  // Counters sit at zero outside SCAN so each scan starts from (0,0,0).
  assign cnt_clr  = (state_q != SC_SCAN) || i_sap_sc_abort;

  sdma_sap_scan_ctrl_axis_cnt #(.W(CW)) u_cnt_c (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .clr_i    (cnt_clr),
    .inc_i    (elem_hs),
    .ext_i    (ext_c_q),
    .cnt_o    (cnt_c),
    .at_end_o (at_end_c),
    .wrap_o   (wrap_c)
  );

  sdma_sap_scan_ctrl_axis_cnt #(.W(XW)) u_cnt_x (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .clr_i    (cnt_clr),
    .inc_i    (wrap_c),
    .ext_i    (ext_x_q[XW-1:0]),
    .cnt_o    (cnt_x),
    .at_end_o (at_end_x),
    .wrap_o   (wrap_x)
  );

  sdma_sap_scan_ctrl_axis_cnt #(.W(YW)) u_cnt_y (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .clr_i    (cnt_clr),
    .inc_i    (wrap_x),
    .ext_i    (ext_y_q[YW-1:0]),
    .cnt_o    (cnt_y),
    .at_end_o (at_end_y),
    .wrap_o   (wrap_y)
  );

  // wrap_y is the handshake on the final coordinate: the scan is complete.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SC_IDLE: begin
        if (start_acc) state_d = SC_CHECK;
      end
      SC_CHECK: begin
        if (i_sap_sc_abort)  state_d = SC_IDLE;
        else if (ext_ovf)    state_d = SC_IDLE;
        else if (ext_zero)   state_d = SC_DONE;
        else                 state_d = SC_SCAN;
      end
      SC_SCAN: begin
        if (i_sap_sc_abort)  state_d = SC_IDLE;
        else if (wrap_y)     state_d = SC_DONE;
      end
      SC_DONE: begin
        state_d = SC_IDLE;
      end
      default: begin
        state_d = SC_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= SC_IDLE;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= (state_q == SC_CHECK) && !i_sap_sc_abort && ext_ovf;
    end
  end

  assign sc_if.sfmsccnt   = cnt_c;
  assign sc_if.sfmsxcnt   = cnt_x;
  assign sc_if.sfmsycnt   = cnt_y;
  assign sc_if.elem_valid = elem_vld;
  assign sc_if.elem_pad   = sc_if.padding_flag;
  assign sc_if.elem_last  = elem_vld && at_end_c && at_end_x && at_end_y;

  assign o_sap_sc_busy    = (state_q != SC_IDLE);
  assign o_sap_sc_done    = (state_q == SC_DONE);
  assign o_sap_sc_cfg_err = cfg_err_q;

`ifdef SDMA_SAP_SCAN_PERF_EN
  logic [31:0] pad_beats_q, data_beats_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pad_beats_q  <= '0;
      data_beats_q <= '0;
    end else if (start_acc) begin
      pad_beats_q  <= '0;
      data_beats_q <= '0;
    end else if (elem_hs) begin
      if (sc_if.padding_flag && (pad_beats_q != 32'hFFFF_FFFF)) begin
        pad_beats_q <= pad_beats_q + 32'd1;
      end
      if (!sc_if.padding_flag && (data_beats_q != 32'hFFFF_FFFF)) begin
        data_beats_q <= data_beats_q + 32'd1;
      end
    end
  end

  assign o_sap_sc_pad_beats  = pad_beats_q;
  assign o_sap_sc_data_beats = data_beats_q;
`endif

endmodule

// File: tb/tb_sdma_sap_scan_ctrl.sv
// Purpose : self-checking bench for sdma_sap_scan_ctrl; a vector table of scan configs plus reset/abort sequences.
// Latency : n/a.
// Backpressure: bench drives elem_ready as all-ones or 1,0,1,0 and models the padding indicator.
module tb_sdma_sap_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, pen;
  logic [15:0] srcc, srcx, srcy;
  logic [7:0]  plx, prx, ply, pry;
  logic        busy, done, cfg_err;
`ifdef SDMA_SAP_SCAN_PERF_EN
  logic [31:0] pad_beats, data_beats;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Padding-indicator model configuration, captured by the bench at start.
  int m_pen, m_x, m_y, m_plx, m_ply;

  always #5 clk = ~clk;

  sdma_sap_scan_ctrl_if sc_if ();

  sdma_sap_scan_ctrl dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_sap_sc_start     (start),
    .i_sap_sc_abort     (abort),
    .i_sap_sc_paddingen (pen),
    .i_sap_sc_srcfmsc   (srcc),
    .i_sap_sc_srcfmsx   (srcx),
    .i_sap_sc_srcfmsy   (srcy),
    .i_sap_sc_padl_x    (plx),
    .i_sap_sc_padr_x    (prx),
    .i_sap_sc_padl_y    (ply),
    .i_sap_sc_padr_y    (pry),
    .sc_if              (sc_if.master),
    .o_sap_sc_busy      (busy),
    .o_sap_sc_done      (done),
    .o_sap_sc_cfg_err   (cfg_err)
`ifdef SDMA_SAP_SCAN_PERF_EN
    ,
    .o_sap_sc_pad_beats (pad_beats),
    .o_sap_sc_data_beats(data_beats)
`endif
  );

  always_comb begin
    sc_if.padding_flag = (m_pen != 0) &&
      ((int'(sc_if.sfmsxcnt) < m_plx) || (int'(sc_if.sfmsxcnt) >= m_plx + m_x) ||
       (int'(sc_if.sfmsycnt) < m_ply) || (int'(sc_if.sfmsycnt) >= m_ply + m_y));
  end

  typedef struct {
    int c, x, y, pen, plx, prx, ply, pry;
    int alt_rdy;   // 1: ready pattern 1,0,1,0
    int inj;       // 0 none, 1 start at beat 2, 2 abort at beat 2
    int e_beats, e_pads, e_done, e_err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int ec, ex, ey, ext_x, ext_y, total;
    int beats, pads, dones, errs;
    bit fin, hold_pend, idle_chk, inj_done;
    longint hold_xyz;
    ext_x = v.pen ? v.plx + v.x + v.prx : v.x;
    ext_y = v.pen ? v.ply + v.y + v.pry : v.y;
    total = v.c * ext_x * ext_y;
    ec = 0; ex = 0; ey = 0;
    beats = 0; pads = 0; dones = 0; errs = 0;
    fin = 0; hold_pend = 0; idle_chk = 0; inj_done = 0; hold_xyz = 0;
    @(negedge clk);
    m_pen = v.pen; m_x = v.x; m_y = v.y; m_plx = v.plx; m_ply = v.ply;
    srcc = 16'(v.c); srcx = 16'(v.x); srcy = 16'(v.y); pen = v.pen[0];
    plx = 8'(v.plx); prx = 8'(v.prx); ply = 8'(v.ply); pry = 8'(v.pry);
    start = 1'b1; sc_if.elem_ready = 1'b1;
    @(negedge clk);
    // Inputs after start must not matter.
    start = 1'b0;
    srcc = 16'($urandom); srcx = 16'($urandom); srcy = 16'($urandom); pen = 1'($urandom);
    plx = 8'($urandom); prx = 8'($urandom); ply = 8'($urandom); pry = 8'($urandom);
    #1;
    chk($sformatf("v%0d check_busy", idx), busy, 1);
    chk($sformatf("v%0d check_novalid", idx), sc_if.elem_valid, 0);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      sc_if.elem_ready = (v.alt_rdy != 0) ? 1'((cyc % 2) == 0) : 1'b1;
      if (!inj_done && beats == 2 && sc_if.elem_valid) begin
        if (v.inj == 1) begin
          start = 1'b1; srcc = 16'd1; srcx = 16'd1; srcy = 16'd1; pen = 1'b0;
          inj_done = 1;
        end else if (v.inj == 2) begin
          abort = 1'b1; sc_if.elem_ready = 1'b0;
          inj_done = 1;
        end
      end
      #1;
      if (cyc == 0) chk($sformatf("v%0d first_valid", idx), sc_if.elem_valid, (v.e_beats > 0) ? 1 : 0);
      if (idle_chk) begin
        chk($sformatf("v%0d abort_valid", idx), sc_if.elem_valid, 0);
        chk($sformatf("v%0d abort_busy", idx), busy, 0);
        idle_chk = 0;
      end
      if (hold_pend) begin
        chk($sformatf("v%0d hold_valid", idx), sc_if.elem_valid, 1);
        chk($sformatf("v%0d hold_xyz", idx),
            {sc_if.sfmsycnt, sc_if.sfmsxcnt, sc_if.sfmsccnt}, hold_xyz);
        hold_pend = 0;
      end
      if (abort) idle_chk = 1;
      if (sc_if.elem_valid && sc_if.elem_ready) begin
        chk($sformatf("v%0d beat%0d xyz", idx, beats),
            {sc_if.sfmsycnt, sc_if.sfmsxcnt, sc_if.sfmsccnt},
            {16'(ey), 16'(ex), 16'(ec)});
        chk($sformatf("v%0d beat%0d last", idx, beats), sc_if.elem_last, (beats == total - 1) ? 1 : 0);
        if (sc_if.elem_pad) pads++;
        beats++;
        ec++;
        if (ec == v.c) begin
          ec = 0; ex++;
          if (ex == ext_x) begin ex = 0; ey++; end
        end
      end else if (sc_if.elem_valid && !abort) begin
        hold_pend = 1;
        hold_xyz = {sc_if.sfmsycnt, sc_if.sfmsxcnt, sc_if.sfmsccnt};
      end
      if (done) dones++;
      if (cfg_err) errs++;
      if (!busy) fin = 1;
    end
    abort = 1'b0; start = 1'b0;
    chk($sformatf("v%0d finished", idx), fin, 1);
    chk($sformatf("v%0d beats", idx), beats, v.e_beats);
    chk($sformatf("v%0d pads", idx), pads, v.e_pads);
    chk($sformatf("v%0d done_pulses", idx), dones, v.e_done);
    chk($sformatf("v%0d cfg_err_pulses", idx), errs, v.e_err);
`ifdef SDMA_SAP_SCAN_PERF_EN
    if (v.e_beats > 0) begin
      chk($sformatf("v%0d perf_pad", idx), pad_beats, v.e_pads);
      chk($sformatf("v%0d perf_data", idx), data_beats, v.e_beats - v.e_pads);
    end
`endif
  endtask

  initial begin
    //           c  x        y        pen plx prx ply pry alt inj beats pads done err
    vecs[0]  = '{2, 2,       1,       0,  0,  0,  0,  0,  0,  0,  4,    0,   1,   0};
    vecs[1]  = '{1, 2,       2,       1,  1,  1,  1,  0,  0,  0,  12,   8,   1,   0};
    vecs[2]  = '{1, 2,       2,       1,  1,  1,  1,  0,  1,  0,  12,   8,   1,   0};
    vecs[3]  = '{2, 0,       3,       0,  0,  0,  0,  0,  0,  0,  0,    0,   1,   0};
    vecs[4]  = '{1, 'hFFFF,  1,       1,  1,  0,  0,  0,  0,  0,  0,    0,   0,   1};
    vecs[5]  = '{3, 1,       2,       0,  0,  0,  0,  0,  0,  0,  6,    0,   1,   0};
    vecs[6]  = '{1, 2,       1,       0,  2,  2,  2,  2,  0,  0,  2,    0,   1,   0};
    vecs[7]  = '{2, 1,       'hFFFE,  1,  0,  0,  1,  1,  0,  0,  0,    0,   0,   1};
    vecs[8]  = '{3, 1,       2,       0,  0,  0,  0,  0,  0,  1,  6,    0,   1,   0};
    vecs[9]  = '{3, 1,       2,       0,  0,  0,  0,  0,  0,  2,  2,    0,   0,   0};
    vecs[10] = '{1, 1,       1,       1,  1,  1,  1,  1,  1,  0,  9,    8,   1,   0};
    vecs[11] = '{0, 2,       2,       1,  1,  1,  1,  1,  0,  0,  0,    0,   1,   0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; pen = 1'b0;
    srcc = '0; srcx = '0; srcy = '0; plx = '0; prx = '0; ply = '0; pry = '0;
    sc_if.elem_ready = 1'b1;
    m_pen = 0; m_x = 0; m_y = 0; m_plx = 0; m_ply = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_valid", sc_if.elem_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cfg_err", cfg_err, 0);
    chk("reset_last", sc_if.elem_last, 0);
    chk("reset_xyz", {sc_if.sfmsycnt, sc_if.sfmsxcnt, sc_if.sfmsccnt}, 0);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Abort and start together in IDLE: abort wins.
    @(negedge clk);
    srcc = 16'd2; srcx = 16'd2; srcy = 16'd1; pen = 1'b0;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #1;
    chk("abort_start_busy", busy, 0);
    @(negedge clk);
    #1;
    chk("abort_start_valid", sc_if.elem_valid, 0);

    // Asynchronous reset in the middle of a padded scan.
    @(negedge clk);
    m_pen = 1; m_x = 2; m_y = 2; m_plx = 1; m_ply = 1;
    srcc = 16'd1; srcx = 16'd2; srcy = 16'd2; pen = 1'b1;
    plx = 8'd1; prx = 8'd1; ply = 8'd1; pry = 8'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("pre_rst_valid", sc_if.elem_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", sc_if.elem_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_last", sc_if.elem_last, 0);
    chk("midrst_done", done, 0);
    chk("midrst_xyz", {sc_if.sfmsycnt, sc_if.sfmsxcnt, sc_if.sfmsccnt}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(100, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
